// File: rtl/load_store_data_gen.sv
// Load/store data alignment: extracts and extends a load field from an aligned word
// and merges store data into that word, both registered with one cycle of latency.
module load_store_data_gen (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   input  logic [31:0] word_i,
   input  logic [31:0] w_data_i,
   input  logic [2:0]  sign_mask_i,
   input  logic [1:0]  byte_offset_i,
   output logic [31:0] load_data_o,
   output logic [31:0] store_word_o,
   output logic        valid_o
);

   localparam int unsigned DataW = 32;
   localparam int unsigned HalfW = 16;
   localparam int unsigned ByteW = 8;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10
   } size_e;

   size_e             size_c;
   logic              zero_ext_c;
   logic [ByteW-1:0]  byte_sel_c;
   logic [HalfW-1:0]  half_sel_c;
   logic [DataW-1:0]  load_d;
   logic [DataW-1:0]  store_d;

   logic [DataW-1:0]  load_q;
   logic [DataW-1:0]  store_q;
   logic              valid_q;

   // Size decode: both 10 and 11 mean a full word.
   always_comb begin
      size_c     = SIZE_WORD;
      zero_ext_c = sign_mask_i[2];
      unique case (sign_mask_i[1:0])
         2'b00:   size_c = SIZE_BYTE;
         2'b01:   size_c = SIZE_HALF;
         default: size_c = SIZE_WORD;
      endcase
   end

   // Lane selection for loads; half selection ignores offset bit 0.
   always_comb begin
      byte_sel_c = word_i[7:0];
      unique case (byte_offset_i)
         2'd0: byte_sel_c = word_i[7:0];
         2'd1: byte_sel_c = word_i[15:8];
         2'd2: byte_sel_c = word_i[23:16];
         2'd3: byte_sel_c = word_i[31:24];
      endcase
      half_sel_c = byte_offset_i[1] ? word_i[31:16] : word_i[15:0];
   end

   always_comb begin
      load_d = word_i;
      unique case (size_c)
         SIZE_BYTE: load_d = {{(DataW-ByteW){~zero_ext_c & byte_sel_c[ByteW-1]}}, byte_sel_c};
         SIZE_HALF: load_d = {{(DataW-HalfW){~zero_ext_c & half_sel_c[HalfW-1]}}, half_sel_c};
         default:   load_d = word_i;
      endcase
   end

   // Store merge: addressed lanes take store data, remaining lanes keep word_i.
   always_comb begin
      store_d = word_i;
      unique case (size_c)
         SIZE_BYTE: begin
            unique case (byte_offset_i)
               2'd0: store_d[7:0]   = w_data_i[7:0];
               2'd1: store_d[15:8]  = w_data_i[7:0];
               2'd2: store_d[23:16] = w_data_i[7:0];
               2'd3: store_d[31:24] = w_data_i[7:0];
            endcase
         end
         SIZE_HALF: begin
            if (byte_offset_i[1]) begin
               store_d[31:16] = w_data_i[15:0];
            end else begin
               store_d[15:0]  = w_data_i[15:0];
            end
         end
         default: store_d = w_data_i;
      endcase
   end

   // Data registers hold when no transaction is captured.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         load_q  <= '0;
         store_q <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_i;
         if (valid_i) begin
            load_q  <= load_d;
            store_q <= store_d;
         end
      end
   end

   assign load_data_o  = load_q;
   assign store_word_o = store_q;
   assign valid_o      = valid_q;

endmodule

// File: tb/tb_load_store_data_gen.sv
// Bench for load_store_data_gen: directed literal vectors plus randomized traffic
// checked every cycle against a lane-arithmetic reference model.
module tb_load_store_data_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic [31:0] word = '0;
   logic [31:0] wdata = '0;
   logic [2:0]  smask = '0;
   logic [1:0]  off = '0;
   logic [31:0] load_data;
   logic [31:0] store_word;
   logic        valid_out;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] exp_load = '0;
   logic [31:0] exp_store = '0;
   logic        exp_valid = 1'b0;
   logic        chk_en = 1'b0;

   always #5 clk = ~clk;

   load_store_data_gen dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .valid_i       (valid),
      .word_i        (word),
      .w_data_i      (wdata),
      .sign_mask_i   (smask),
      .byte_offset_i (off),
      .load_data_o   (load_data),
      .store_word_o  (store_word),
      .valid_o       (valid_out)
   );

   function automatic int nbytes_of(input logic [2:0] sm);
      if (sm[1:0] == 2'd0) return 1;
      if (sm[1:0] == 2'd1) return 2;
      return 4;
   endfunction

   function automatic int base_of(input int nb, input logic [1:0] o);
      if (nb == 4) return 0;
      if (nb == 2) return (int'(o) / 2) * 2;
      return int'(o);
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] sm, input logic [1:0] o);
      int nb, base;
      logic [63:0] mask, field;
      nb = nbytes_of(sm);
      if (nb == 4) return w;
      base  = base_of(nb, o);
      mask  = (64'd1 << (8 * nb)) - 64'd1;
      field = ({32'd0, w} >> (8 * base)) & mask;
      if (!sm[2] && field[8*nb-1]) field = field | (~mask);
      return field[31:0];
   endfunction

   function automatic logic [31:0] m_store(input logic [31:0] w, input logic [31:0] wd,
                                           input logic [2:0] sm, input logic [1:0] o);
      int nb, base;
      logic [31:0] r;
      nb = nbytes_of(sm);
      base = base_of(nb, o);
      r = w;
      for (int i = 0; i < nb; i++) r[8*(base+i) +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   // Reference model: registers exactly what a capture on this edge must produce.
   always @(posedge clk) begin
      if (rst) begin
         exp_load  <= '0;
         exp_store <= '0;
         exp_valid <= 1'b0;
         chk_en    <= 1'b1;
      end else begin
         exp_valid <= valid;
         if (valid) begin
            exp_load  <= m_load(word, smask, off);
            exp_store <= m_store(word, wdata, smask, off);
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         vectors++;
         if (load_data !== exp_load || store_word !== exp_store || valid_out !== exp_valid) begin
            miscompares++;
            $display("FAIL model t=%0t load=%h/%h store=%h/%h valid=%b/%b (actual/required)",
                     $time, load_data, exp_load, store_word, exp_store, valid_out, exp_valid);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic step(input logic r, input logic v, input logic [31:0] w, input logic [31:0] wd,
                       input logic [2:0] sm, input logic [1:0] o);
      rst = r; valid = v; word = w; wdata = wd; smask = sm; off = o;
      @(posedge clk);
      @(negedge clk);
   endtask

   localparam logic [31:0] W0 = 32'h80FF7F01;

   initial begin
      step(1'b1, 1'b0, '0, '0, '0, '0);
      step(1'b1, 1'b0, '0, '0, '0, '0);
      check("reset_load", load_data, 32'h0);
      check("reset_store", store_word, 32'h0);
      check("reset_valid", {31'd0, valid_out}, 32'h0);

      step(1'b0, 1'b1, W0, 32'h0, 3'b000, 2'd1);
      check("lb_off1", load_data, 32'h0000007F);
      check("lb_valid", {31'd0, valid_out}, 32'h1);
      step(1'b0, 1'b1, W0, 32'h0, 3'b000, 2'd3);
      check("lb_off3_sext", load_data, 32'hFFFFFF80);
      step(1'b0, 1'b1, W0, 32'h0, 3'b100, 2'd3);
      check("lbu_off3", load_data, 32'h00000080);

      step(1'b0, 1'b1, W0, 32'h0, 3'b001, 2'd2);
      check("lh_off2", load_data, 32'hFFFF80FF);
      step(1'b0, 1'b1, W0, 32'h0, 3'b101, 2'd2);
      check("lhu_off2", load_data, 32'h000080FF);
      step(1'b0, 1'b1, W0, 32'h0, 3'b001, 2'd3);
      check("lh_off3", load_data, 32'hFFFF80FF);
      step(1'b0, 1'b1, W0, 32'h0, 3'b001, 2'd0);
      check("lh_off0", load_data, 32'h00007F01);

      step(1'b0, 1'b1, W0, 32'h123456AB, 3'b000, 2'd2);
      check("sb_off2", store_word, 32'h80AB7F01);
      step(1'b0, 1'b1, W0, 32'hDEADBEEF, 3'b001, 2'd2);
      check("sh_off2", store_word, 32'hBEEF7F01);
      step(1'b0, 1'b1, W0, 32'hDEADBEEF, 3'b010, 2'd1);
      check("sw", store_word, 32'hDEADBEEF);
      check("lw_010", load_data, W0);
      step(1'b0, 1'b1, W0, 32'hDEADBEEF, 3'b110, 2'd3);
      check("lw_110", load_data, W0);

      step(1'b0, 1'b0, 32'h11223344, 32'h55667788, 3'b000, 2'd0);
      check("hold_valid", {31'd0, valid_out}, 32'h0);
      check("hold_load", load_data, W0);
      check("hold_store", store_word, 32'hDEADBEEF);

      step(1'b1, 1'b1, W0, 32'hDEADBEEF, 3'b000, 2'd1);
      check("rst_mid_load", load_data, 32'h0);
      check("rst_mid_store", store_word, 32'h0);
      check("rst_mid_valid", {31'd0, valid_out}, 32'h0);
      step(1'b0, 1'b1, W0, 32'h123456AB, 3'b000, 2'd1);
      check("post_rst_load", load_data, 32'h0000007F);
      check("post_rst_store", store_word, 32'h80FFAB01);
      check("post_rst_valid", {31'd0, valid_out}, 32'h1);

      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), $urandom, $urandom,
              3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
